// File: rtl/pwm_carrier_mask.sv
// Carrier generator and update-event source for one PWM channel: sawtooth or
// triangular count, zero/peak event decode and a decimated shadow-load strobe.
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

package PKG_pwm;
  typedef enum logic {
    PWM_OFF = 1'b0,
    PWM_ON  = 1'b1
  } _pwm_onoff;
endpackage

// state | meaning
// IDLE  | carrier parked at min(init_val, period), decimation cleared
// RUN   | carrier counting, events decoded, maskevent generated
module pwm_carrier_mask
  import PKG_pwm::*;
#(
  parameter int WIDTH = `PWMCOUNT_WIDTH,
  parameter int MASKW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  _pwm_onoff        pwm_onoff,
  input  logic             carrier_mode,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] init_val,
  input  logic [1:0]       event_sel,
  input  logic [MASKW-1:0] mask_n,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             zero_evt,
  output logic             peak_evt,
  output logic             maskevent
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [MASKW-1:0] mcnt;
  logic [WIDTH-1:0] count_nxt;
  logic             dir_nxt;
  logic [WIDTH-1:0] park_val;
  logic             running;
  logic             park;
  logic             period_ok;
  logic             qual_evt;
  logic             mask_hit;

  assign running   = (state == RUN);
  assign park      = !running || (pwm_onoff != PWM_ON);
  assign period_ok = (period != '0);
  assign park_val  = (init_val < period) ? init_val : period;

  assign zero_evt  = running && period_ok && (count == '0);
  assign peak_evt  = running && period_ok && (count == period);
  assign qual_evt  = (event_sel[0] && zero_evt) || (event_sel[1] && peak_evt);

  // >= rather than == so that lowering mask_n below mcnt fires on the next event.
  assign mask_hit  = (mcnt >= mask_n);

  always_comb begin
    count_nxt = count;
    dir_nxt   = dir;
    if (!period_ok) begin
      count_nxt = '0;
      dir_nxt   = 1'b1;
    end else if (!carrier_mode) begin
      count_nxt = (count >= period) ? '0 : count + WIDTH'(1);
      dir_nxt   = 1'b1;
    end else if (dir) begin
      if (count >= period) begin
        count_nxt = period - WIDTH'(1);
        dir_nxt   = 1'b0;
      end else begin
        count_nxt = count + WIDTH'(1);
      end
    end else begin
      // A count above a freshly lowered period simply keeps falling.
      if (count == '0) begin
        count_nxt = WIDTH'(1);
        dir_nxt   = 1'b1;
      end else begin
        count_nxt = count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      dir       <= 1'b1;
      mcnt      <= '0;
      maskevent <= 1'b0;
    end else begin
      state <= (pwm_onoff == PWM_ON) ? RUN : IDLE;
      if (park) begin
        // Turning off also swallows any strobe that was due this edge.
        count     <= park_val;
        dir       <= 1'b1;
        mcnt      <= '0;
        maskevent <= 1'b0;
      end else begin
        count <= count_nxt;
        dir   <= dir_nxt;
        if (qual_evt) begin
          if (mask_hit) begin
            maskevent <= 1'b1;
            mcnt      <= '0;
          end else begin
            maskevent <= 1'b0;
            mcnt      <= mcnt + MASKW'(1);
          end
        end else begin
          maskevent <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_carrier_mask.sv
// Self-checking bench for pwm_carrier_mask: directed waveform checks plus a
// randomized run compared every cycle against a waveform-level reference model.
module tb_pwm_carrier_mask;
  import PKG_pwm::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  _pwm_onoff    onoff;
  logic         mode;
  logic [W-1:0] period;
  logic [W-1:0] init_val;
  logic [1:0]   es;
  logic [3:0]   mask_n;
  logic [W-1:0] count;
  logic         dir;
  logic         zero_evt;
  logic         peak_evt;
  logic         maskevent;

  int checks = 0;
  int errors = 0;

  pwm_carrier_mask #(.WIDTH(W), .MASKW(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .pwm_onoff   (onoff),
    .carrier_mode(mode),
    .period      (period),
    .init_val    (init_val),
    .event_sel   (es),
    .mask_n      (mask_n),
    .count       (count),
    .dir         (dir),
    .zero_evt    (zero_evt),
    .peak_evt    (peak_evt),
    .maskevent   (maskevent)
  );

  always #5 clk = ~clk;

  // Reference model: position on the carrier waveform plus an event tally.
  logic [W-1:0] m_count = '0;
  bit           m_dir   = 1'b1;
  bit           m_run   = 1'b0;
  bit           m_me    = 1'b0;
  int           m_mcnt  = 0;

  function automatic bit m_zero();
    return m_run && (period != 0) && (m_count == 0);
  endfunction

  function automatic bit m_peak();
    return m_run && (period != 0) && (m_count == period);
  endfunction

  always @(posedge clk) begin
    bit q;
    if (reset) begin
      m_run = 0; m_count = '0; m_dir = 1; m_mcnt = 0; m_me = 0;
    end else begin
      q = (es[0] && m_zero()) || (es[1] && m_peak());
      if (!m_run || onoff == PWM_OFF) begin
        m_count = (init_val < period) ? init_val : period;
        m_dir = 1; m_mcnt = 0; m_me = 0;
      end else begin
        if (period == 0) begin
          m_count = '0; m_dir = 1;
        end else if (!mode) begin
          m_count = (m_count >= period) ? 16'd0 : m_count + 16'd1;
          m_dir = 1;
        end else if (m_dir) begin
          if (m_count >= period) begin m_count = period - 16'd1; m_dir = 0; end
          else m_count = m_count + 16'd1;
        end else begin
          if (m_count == 0) begin m_count = 16'd1; m_dir = 1; end
          else m_count = m_count - 16'd1;
        end
        m_me = q && (m_mcnt >= int'(mask_n));
        if (q) m_mcnt = m_me ? 0 : m_mcnt + 1;
      end
      m_run = (onoff == PWM_ON);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("model_count", 32'(count), 32'(m_count));
    chk("model_dir", 32'(dir), 32'(m_dir));
    chk("model_zero_evt", 32'(zero_evt), 32'(m_zero()));
    chk("model_peak_evt", 32'(peak_evt), 32'(m_peak()));
    chk("model_maskevent", 32'(maskevent), 32'(m_me));
  endtask

  // Park with new settings for one edge, then turn on; the next tick is the first RUN cycle.
  task automatic go(input logic md, input logic [W-1:0] p, input logic [W-1:0] iv,
                    input logic [1:0] sel, input logic [3:0] mn);
    onoff = PWM_OFF; mode = md; period = p; init_val = iv; es = sel; mask_n = mn;
    tick();
    onoff = PWM_ON;
  endtask

  int saw_cnt[7] = '{0, 1, 2, 3, 4, 0, 1};
  int saw_me[7]  = '{0, 1, 0, 0, 0, 0, 1};
  int tri_cnt[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
  int tri_dir[8] = '{1, 1, 1, 1, 0, 0, 0, 1};
  int tri_me[8]  = '{0, 1, 0, 0, 1, 0, 0, 1};

  initial begin
    reset = 1; onoff = PWM_OFF; mode = 0; period = 16'd4; init_val = '0; es = 2'b01; mask_n = '0;
    tick();
    tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_dir", 32'(dir), 1);
    chk("rst_zero", 32'(zero_evt), 0);
    chk("rst_peak", 32'(peak_evt), 0);
    chk("rst_maskevent", 32'(maskevent), 0);
    reset = 0;

    go(1'b0, 16'd4, 16'd0, 2'b01, 4'd0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("saw4_count", 32'(count), 32'(saw_cnt[i]));
      chk("saw4_zero", 32'(zero_evt), 32'(saw_cnt[i] == 0));
      chk("saw4_maskevent", 32'(maskevent), 32'(saw_me[i]));
    end

    go(1'b1, 16'd3, 16'd0, 2'b11, 4'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("tri3_count", 32'(count), 32'(tri_cnt[i]));
      chk("tri3_dir", 32'(dir), 32'(tri_dir[i]));
      chk("tri3_maskevent", 32'(maskevent), 32'(tri_me[i]));
    end

    go(1'b0, 16'd2, 16'd0, 2'b10, 4'd2);
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("dec_peak", 32'(peak_evt), 32'(i % 3 == 0));
      chk("dec_maskevent", 32'(maskevent), 32'(i == 10 || i == 19));
    end

    go(1'b0, 16'd5, 16'd7, 2'b10, 4'd0);
    tick();
    chk("off_first_count", 32'(count), 5);
    chk("off_first_peak", 32'(peak_evt), 1);
    onoff = PWM_OFF;
    tick();
    chk("off_count", 32'(count), 5);
    chk("off_maskevent", 32'(maskevent), 0);
    chk("off_mcnt", 32'(dut.mcnt), 0);
    chk("off_peak", 32'(peak_evt), 0);
    onoff = PWM_ON;
    tick();
    chk("on_count", 32'(count), 5);
    chk("on_peak", 32'(peak_evt), 1);
    tick();
    chk("on_wrap_count", 32'(count), 0);
    chk("on_maskevent", 32'(maskevent), 1);

    go(1'b0, 16'd20, 16'd10, 2'b11, 4'd0);
    tick();
    chk("live_saw_start", 32'(count), 10);
    period = 16'd5;
    tick();
    chk("live_saw_count", 32'(count), 0);
    go(1'b1, 16'd20, 16'd10, 2'b11, 4'd0);
    tick();
    chk("live_tri_start", 32'(count), 10);
    period = 16'd5;
    tick();
    chk("live_tri_count", 32'(count), 4);
    chk("live_tri_dir", 32'(dir), 0);

    go(1'b1, 16'd3, 16'd2, 2'b11, 4'd0);
    tick();
    tick();
    tick();
    chk("midrst_pre_count", 32'(count), 2);
    chk("midrst_pre_dir", 32'(dir), 0);
    reset = 1;
    tick();
    chk("midrst_count", 32'(count), 0);
    chk("midrst_dir", 32'(dir), 1);
    chk("midrst_zero", 32'(zero_evt), 0);
    chk("midrst_peak", 32'(peak_evt), 0);
    chk("midrst_maskevent", 32'(maskevent), 0);
    reset = 0;
    tick();
    chk("restart_count", 32'(count), 2);
    chk("restart_dir", 32'(dir), 1);
    tick();
    chk("restart_up_count", 32'(count), 3);
    chk("restart_peak", 32'(peak_evt), 1);

    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      onoff = ($urandom_range(0, 39) == 0) ? PWM_OFF : PWM_ON;
      if ($urandom_range(0, 49) == 0) mode = $urandom_range(0, 1);
      if ($urandom_range(0, 59) == 0) begin
        case ($urandom_range(0, 5))
          0:       begin period = 16'hFFFF; init_val = 16'hFFF0 + 16'($urandom_range(0, 15)); end
          1:       period = '0;
          default: period = 16'($urandom_range(1, 12));
        endcase
      end
      if ($urandom_range(0, 19) == 0) init_val = 16'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) es = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) mask_n = 4'($urandom_range(0, 5));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_carrier_mask.md
# pwm_carrier_mask

Carrier generator and update-event source for one PWM channel. It produces the 16-bit carrier count (sawtooth or triangular), the zero and peak event pulses, and a decimated `maskevent` strobe. `maskevent` feeds the downstream 16-bit masked shadow registers, which load new compare and period values only on that strobe or while the channel is off. It sits directly upstream of those registers and of the compare stage.

## Interface
Parameters:
- `WIDTH`, default `` `PWMCOUNT_WIDTH `` (16): carrier/period width.
- `MASKW`, default 4: width of the event-decimation counter.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `pwm_onoff`  in  `_pwm_onoff` (PKG_pwm)  `PWM_ON` runs the carrier; `PWM_OFF` parks it.
- `carrier_mode`  in  1  0 = sawtooth up-count; 1 = triangular up/down.
- `period`  in  WIDTH  carrier peak value, used live.
- `init_val`  in  WIDTH  count loaded while parked.
- `event_sel`  in  2  bit0 qualifies zero events; bit1 qualifies peak events.
- `mask_n`  in  MASKW  number of qualifying events skipped between strobes.
- `count`  out  WIDTH  carrier value (registered).
- `dir`  out  1  1 = counting up, 0 = counting down.
- `zero_evt`  out  1  high while running and `count==0`.
- `peak_evt`  out  1  high while running and `count==period`.
- `maskevent`  out  1  single-cycle update strobe (registered).

## Operation
- States:
  - IDLE: entered on reset or `pwm_onoff==PWM_OFF`.
  - RUN: entered on `pwm_onoff==PWM_ON`.
  - Transitions take effect on the next clock edge.
- IDLE, every cycle:
  - `count <= min(init_val, period)`, `dir <= 1`.
  - Decimation counter `mcnt <= 0`, `maskevent <= 0`.
  - `zero_evt` and `peak_evt` are 0.
- RUN, `period==0`: `count <= 0`, `dir <= 1`, no events.
- RUN, sawtooth:
  - If `count >= period`: `count <= 0`.
  - Otherwise `count <= count+1`.
  - `dir` is held at 1.
- RUN, triangular, `dir==1`:
  - If `count >= period`: `count <= period-1`, `dir <= 0`.
  - Otherwise `count <= count+1`.
- RUN, triangular, `dir==0`:
  - If `count==0`: `count <= 1`, `dir <= 1`.
  - Otherwise `count <= count-1`.
  - If `count > period` while counting down, it keeps decrementing normally.
- Event decode (combinational from registered state and `count`, `period!=0` required):
  - `zero_evt = RUN & count==0`.
  - `peak_evt = RUN & count==period`.
- Qualifying event: `q = (event_sel[0] & zero_evt) | (event_sel[1] & peak_evt)`.
- Decimation, on `q`:
  - If `mcnt==mask_n`: `maskevent <= 1`, `mcnt <= 0`.
  - Otherwise `mcnt <= mcnt+1`, `maskevent <= 0`.
  - When `q==0`: `maskevent <= 0`.
- `mask_n` is sampled at each comparison. If `mask_n` is lowered below `mcnt`, the next `q` fires and clears `mcnt` (`mcnt >= mask_n` compare).
- Arithmetic is unsigned WIDTH-bit with no wrap: `period=0xFFFF` reaches 0xFFFF, then wraps to 0 in sawtooth mode or turns down in triangular mode.

## Timing
- Reset values:
  - `count=0`, `dir=1`, `zero_evt=0`, `peak_evt=0`, `maskevent=0`, `mcnt=0`, state IDLE.
  - Reset has priority over `pwm_onoff`.
- Latency:
  - `maskevent` asserts exactly one cycle after the cycle in which `q=1`.
  - It is high for exactly one cycle.
- Sawtooth period is `period+1` cycles. Triangular period is `2*period` cycles.
- First RUN cycle: `count` holds the parked value. An event fires if that value is 0 or equals `period`.
- `PWM_OFF` during RUN: next cycle is IDLE and any `maskevent` due that cycle is suppressed. Downstream registers are already transparent while off.
- Reset mid-run returns the block to reset values on the next edge.

## Test plan
- Sawtooth, `period=4`, `init_val=0`, `event_sel=01`, `mask_n=0`:
  - `count` = 0,1,2,3,4,0,…
  - `zero_evt` pulses every 5 cycles.
  - `maskevent` pulses one cycle after each `zero_evt`.
- Triangular, `period=3`, `event_sel=11`, `mask_n=0`:
  - `count` = 0,1,2,3,2,1,0,1,…
  - `dir` falls in the cycle after `count=3`.
  - `maskevent` pulses every 3 cycles.
- Sawtooth, `period=2`, `event_sel=10`, `mask_n=2`:
  - `peak_evt` pulses every 3 cycles.
  - `maskevent` pulses once every 9 cycles, after every third peak.
- `PWM_OFF` asserted in the same cycle as a qualifying event, with `init_val=7`, `period=5`:
  - Next cycle `count=5`, `maskevent=0`, `mcnt=0`.
  - On `PWM_ON`, the first cycle shows `count=5` with `peak_evt=1`.
- Live period reduction: while running at `count=10`, set `period=5`:
  - Sawtooth: next `count=0`.
  - Triangular, `dir=1`: next `count=4`, `dir=0`.
- `reset` pulsed for one cycle mid-triangle at `count=2`, `dir=0`:
  - Next cycle all outputs are at reset values.
  - With `PWM_ON` held, the carrier restarts from `min(init_val, period)`, counting up.
